// File: rtl/dram_request_scheduler.sv
// Round-robin two-port request queue feeding command_gen.
// Optional statistics counters are enabled with SCHED_STATS_EN.
module dram_request_scheduler #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [66:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [66:0]      req1_data,
  output logic             req1_ready,
  input  logic             inc,
  input  logic             ext_load,
  output logic [67:0]      request_out,
  output logic [15:0]      next_row,
  output logic [PTR_W:0]   queue_count,
  output logic             overflow_err
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]      stat_grant0,
  output logic [15:0]      stat_grant1,
  output logic [15:0]      stat_row_hits,
  output logic [15:0]      stat_idle_loads
`endif
);

  localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] L_TWO  = (PTR_W+1)'(2);

  logic [66:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W:0]   r_count;
  logic             r_rr;
  logic             r_ovf;

  logic             w_full;
  logic             w_rdy0;
  logic             w_rdy1;
  logic             w_push0;
  logic             w_push1;
  logic             w_push;
  logic             w_pop;
  logic             w_both;
  logic [66:0]      w_head;
  logic [66:0]      w_next;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [66:0]      w_wdata;

  assign w_full = (r_count == L_FULL);
  assign w_both = req0_valid & req1_valid;

  always_comb begin
    w_rdy0 = 1'b0;
    w_rdy1 = 1'b0;
    if (!reset && !w_full) begin
      if (w_both) begin
        w_rdy0 = ~r_rr;
        w_rdy1 = r_rr;
      end else begin
        w_rdy0 = req0_valid;
        w_rdy1 = req1_valid;
      end
    end
  end

  assign w_push0 = req0_valid & w_rdy0;
  assign w_push1 = req1_valid & w_rdy1;
  assign w_push  = w_push0 | w_push1;
  assign w_pop   = inc & (r_count != '0);

  // Bit 66 of the stored entry carries the source port.
  assign w_wdata = w_push1 ? {1'b1, req1_data[65:0]}
                           : {1'b0, req0_data[65:0]};

  assign w_rd_nxt = r_rd + 1'b1;
  assign w_head   = r_mem[r_rd];
  assign w_next   = r_mem[w_rd_nxt];

  assign req0_ready   = w_rdy0;
  assign req1_ready   = w_rdy1;
  assign queue_count  = r_count;
  assign overflow_err = r_ovf;
  assign request_out  = {(r_count != '0) & ~reset, w_head};

  // A lone head reports an inverted row so command_gen precharges.
  assign next_row = (r_count >= L_TWO) ? w_next[63:48]
                                       : ~w_head[63:48];

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_rr    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= w_rd_nxt;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_push && w_both) begin
        r_rr <= ~r_rr;
      end
      if (inc && r_count == '0) begin
        r_ovf <= 1'b1;
      end
    end
  end

`ifdef SCHED_STATS_EN
  logic [15:0] r_g0;
  logic [15:0] r_g1;
  logic [15:0] r_hits;
  logic [15:0] r_idle;
  logic        w_hit;
  logic        w_unused;

  assign w_hit = w_pop && (r_count >= L_TWO) &&
                 (w_head[63:48] == w_next[63:48]);
  assign w_unused = ^{req0_data[66], req1_data[66]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_g0   <= '0;
      r_g1   <= '0;
      r_hits <= '0;
      r_idle <= '0;
    end else begin
      if (w_push0 && r_g0 != 16'hFFFF) r_g0 <= r_g0 + 16'd1;
      if (w_push1 && r_g1 != 16'hFFFF) r_g1 <= r_g1 + 16'd1;
      if (w_hit && r_hits != 16'hFFFF) r_hits <= r_hits + 16'd1;
      if (ext_load && r_idle != 16'hFFFF) r_idle <= r_idle + 16'd1;
    end
  end

  assign stat_grant0     = r_g0;
  assign stat_grant1     = r_g1;
  assign stat_row_hits   = r_hits;
  assign stat_idle_loads = r_idle;
`else
  logic w_unused;
  assign w_unused = ^{req0_data[66], req1_data[66], ext_load};
`endif

endmodule

// File: tb/tb_dram_request_scheduler.sv
// Bench for dram_request_scheduler: arbitration table plus
// scoreboard model of the queue, head, next_row and counters.
module tb_dram_request_scheduler;

  logic        clk;
  logic        reset;
  logic        req0_valid;
  logic [66:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [66:0] req1_data;
  logic        req1_ready;
  logic        inc;
  logic        ext_load;
  logic [67:0] request_out;
  logic [15:0] next_row;
  logic [3:0]  queue_count;
  logic        overflow_err;
`ifdef SCHED_STATS_EN
  logic [15:0] stat_grant0;
  logic [15:0] stat_grant1;
  logic [15:0] stat_row_hits;
  logic [15:0] stat_idle_loads;
`endif

  dram_request_scheduler #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .req0_valid(req0_valid),
    .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data(req1_data),
    .req1_ready(req1_ready),
    .inc(inc),
    .ext_load(ext_load),
    .request_out(request_out),
    .next_row(next_row),
    .queue_count(queue_count),
    .overflow_err(overflow_err)
`ifdef SCHED_STATS_EN
    ,
    .stat_grant0(stat_grant0),
    .stat_grant1(stat_grant1),
    .stat_row_hits(stat_row_hits),
    .stat_idle_loads(stat_idle_loads)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [66:0] sb[$];
  logic        m_rr;
  logic        m_ovf;
  int          m_g0, m_g1, m_hit, m_idle;

  typedef struct {
    logic v0;
    logic v1;
    logic r0;
    logic r1;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [67:0] act,
                     input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [66:0] mk(input logic [15:0] row,
                                     input logic [10:0] col,
                                     input logic [31:0] d,
                                     input logic wr);
    return {1'b0, 1'b0, wr, row, col, 5'b0, d};
  endfunction

  task automatic drive(input logic v0, input logic [66:0] d0,
                       input logic v1, input logic [66:0] d1,
                       input logic i, input logic e);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    inc        = i;
    ext_load   = e;
  endtask

  task automatic cycle();
    logic        e0, e1;
    logic [15:0] nr;
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!reset && sb.size() != 8) begin
      if (req0_valid && req1_valid) begin
        e0 = ~m_rr;
        e1 = m_rr;
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
    end
    chk("count", 68'(queue_count), 68'(sb.size()));
    chk("req0_ready", 68'(req0_ready), 68'(e0));
    chk("req1_ready", 68'(req1_ready), 68'(e1));
    chk("out_valid", 68'(request_out[67]),
        68'((sb.size() != 0) && !reset));
    if (!reset && sb.size() != 0) begin
      chk("head", 68'(request_out[66:0]), 68'(sb[0]));
      if (sb.size() >= 2) nr = sb[1][63:48];
      else nr = ~sb[0][63:48];
      chk("next_row", 68'(next_row), 68'(nr));
    end
    chk("overflow_err", 68'(overflow_err), 68'(m_ovf));
`ifdef SCHED_STATS_EN
    chk("stat_grant0", 68'(stat_grant0), 68'(m_g0));
    chk("stat_grant1", 68'(stat_grant1), 68'(m_g1));
    chk("stat_row_hits", 68'(stat_row_hits), 68'(m_hit));
    chk("stat_idle", 68'(stat_idle_loads), 68'(m_idle));
`endif
    if (reset) begin
      sb.delete();
      m_rr = 0; m_ovf = 0;
      m_g0 = 0; m_g1 = 0; m_hit = 0; m_idle = 0;
    end else begin
      if (inc) begin
        if (sb.size() != 0) begin
          if (sb.size() >= 2 && sb[0][63:48] == sb[1][63:48])
            m_hit++;
          void'(sb.pop_front());
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (e0) begin
        sb.push_back({1'b0, req0_data[65:0]});
        m_g0++;
      end else if (e1) begin
        sb.push_back({1'b1, req1_data[65:0]});
        m_g1++;
      end
      if (req0_valid && req1_valid && (e0 || e1)) m_rr = ~m_rr;
      if (ext_load) m_idle++;
    end
    @(posedge clk);
    #1;
  endtask

  logic [66:0] z;
  logic [67:0] exp1;

  initial begin
    z = '0;
    tbl[0] = '{v0: 0, v1: 0, r0: 0, r1: 0};
    tbl[1] = '{v0: 1, v1: 0, r0: 1, r1: 0};
    tbl[2] = '{v0: 0, v1: 1, r0: 0, r1: 1};
    tbl[3] = '{v0: 1, v1: 1, r0: 1, r1: 0};
    m_rr = 0; m_ovf = 0;
    m_g0 = 0; m_g1 = 0; m_hit = 0; m_idle = 0;

    reset = 1'b1;
    drive(1, z, 1, z, 1, 0);
    @(posedge clk);
    #1;
    cycle();
    reset = 1'b0;
    drive(0, z, 0, z, 0, 0);

    for (int i = 0; i < 4; i++) begin
      req0_valid = tbl[i].v0;
      req1_valid = tbl[i].v1;
      #1;
      chk("tbl_r0", 68'(req0_ready), 68'(tbl[i].r0));
      chk("tbl_r1", 68'(req1_ready), 68'(tbl[i].r1));
    end
    drive(0, z, 0, z, 0, 0);

    drive(1, mk(16'h0012, 11'h005, 32'hDEADBEEF, 1), 0, z, 0, 0);
    cycle();
    drive(0, z, 0, z, 0, 0);
    #1;
    exp1 = {1'b1, 1'b0, 1'b0, 1'b1, 16'h0012, 11'h005, 5'h0,
            32'hDEADBEEF};
    chk("first_push_out", request_out, exp1);
    chk("first_push_nrow", 68'(next_row), 68'(16'hFFED));
    drive(0, z, 0, z, 1, 0);
    cycle();

    for (int i = 0; i < 10; i++) begin
      drive(1, mk(16'(i), 11'(i), $urandom, 0),
            1, mk(16'(i + 100), 11'(i), $urandom, 1),
            sb.size() != 0, 0);
      cycle();
    end
    while (sb.size() != 0) begin
      drive(0, z, 0, z, 1, 0);
      cycle();
    end

    drive(1, mk(16'h0004, 11'h1, 32'h1, 0), 0, z, 0, 0);
    cycle();
    drive(1, mk(16'h0004, 11'h2, 32'h2, 0), 0, z, 0, 0);
    cycle();
    drive(1, mk(16'h0007, 11'h3, 32'h3, 0), 0, z, 0, 0);
    cycle();
    drive(0, z, 0, z, 0, 0);
    #1;
    chk("rows_nrow0", 68'(next_row), 68'(16'h0004));
    drive(0, z, 0, z, 1, 0);
    cycle();
    chk("rows_nrow1", 68'(next_row), 68'(16'h0007));
    cycle();
    drive(0, z, 0, z, 0, 0);
    #1;
    chk("rows_nrow2", 68'(next_row), 68'(16'hFFF8));

    for (int i = 0; i < 10; i++) begin
      if (sb.size() < 8) begin
        drive(1, mk(16'(i * 3), 11'(i), $urandom, 1), 0, z, 0, 0);
        cycle();
      end
    end
    drive(1, z, 1, z, 0, 0);
    cycle();
    chk("full_count", 68'(queue_count), 68'(8));
    drive(1, mk(16'h0055, 11'h0, 32'h0, 0), 0, z, 1, 0);
    cycle();
    chk("full_pop_count", 68'(queue_count), 68'(7));
    chk("full_pop_rdy", 68'(req0_ready), 68'(1));

    drive(0, z, 0, z, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (sb.size() != 0) begin
        drive(0, z, 0, z, 1, 0);
        cycle();
      end
    end
    drive(0, z, 0, z, 1, 0);
    cycle();
    drive(0, z, 0, z, 0, 0);
    cycle();
    chk("empty_inc_ovf", 68'(overflow_err), 68'(1));
    chk("empty_inc_cnt", 68'(queue_count), 68'(0));
    for (int i = 0; i < 3; i++) begin
      drive(1, mk(16'(i), 11'h0, 32'h0, 0), 0, z, 0, 0);
      cycle();
    end
    reset = 1'b1;
    drive(0, z, 0, z, 0, 0);
    cycle();
    reset = 1'b0;
    chk("rst_count", 68'(queue_count), 68'(0));
    chk("rst_valid", 68'(request_out[67]), 68'(0));
    chk("rst_ovf", 68'(overflow_err), 68'(0));

    drive(0, z, 1, mk(16'h0009, 11'h1, 32'hA, 0), 0, 0);
    cycle();
    drive(0, z, 1, mk(16'h0009, 11'h2, 32'hB, 0), 0, 1);
    cycle();
    drive(0, z, 1, mk(16'h0001, 11'h3, 32'hC, 0), 0, 1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, z, 0, z, 1, 0);
      cycle();
    end
    drive(0, z, 0, z, 0, 0);
    cycle();
`ifdef SCHED_STATS_EN
    chk("stats_g1", 68'(stat_grant1), 68'(3));
    chk("stats_idle", 68'(stat_idle_loads), 68'(2));
    chk("stats_hits", 68'(stat_row_hits), 68'(1));
    chk("stats_g0", 68'(stat_grant0), 68'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
